// File: rtl/cruise_sequencer.sv
// cruise_sequencer: compare/adjust cruise-control sequencer driving an external ALU comparator.
// Optional CRUISE_RESUME_EN keeps the target through SUSPEND and enables the resume pulse.
module cruise_sequencer #(
  parameter int         ADJ_CYCLES = 4,
  parameter logic [7:0] MIN_SPEED  = 8'd30,
  parameter logic [7:0] MAX_SPEED  = 8'd200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cruise_on,
  input  logic       set,
  input  logic       brake,
  input  logic       resume,
  input  logic [7:0] c_speed,
  input  logic       alu_G,
  input  logic       alu_EQ,
  input  logic       alu_L,
  output logic [1:0] mode,
  output logic [7:0] d_speed,
  output logic [7:0] alu_c_speed,
  output logic       throttle_up,
  output logic       throttle_down,
  output logic       cruise_active,
  output logic [7:0] target_speed
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CMP     = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_ACCEL   = 3'd4;
  localparam logic [2:0] S_DECEL   = 3'd5;
  localparam logic [2:0] S_SUSPEND = 3'd6;
  localparam int         CW        = $clog2(ADJ_CYCLES + 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    d_speed_q, alu_c_speed_q;
  logic          up_q, down_q, active_q;
  logic          in_range, set_ok, adj_done;

  assign in_range = (c_speed >= MIN_SPEED) && (c_speed <= MAX_SPEED);
  assign adj_done = cnt_q == CW'(ADJ_CYCLES - 1);
`ifdef CRUISE_RESUME_EN
  assign set_ok   = set && in_range && state_q != S_IDLE;
`else
  logic unused_resume;
  assign unused_resume = resume;
  assign set_ok   = set && in_range && state_q != S_IDLE && state_q != S_SUSPEND;
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    if (!cruise_on) begin
      state_d = S_IDLE;
      tgt_d   = '0;
    end else if (brake && state_q != S_IDLE) begin
      state_d = S_SUSPEND;
`ifndef CRUISE_RESUME_EN
      tgt_d   = '0;
`endif
    end else if (set_ok) begin
      state_d = S_CMP;
      tgt_d   = c_speed;
`ifdef CRUISE_RESUME_EN
    end else if (resume && state_q == S_SUSPEND && tgt_q != '0) begin
      state_d = S_CMP;
`endif
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_ARMED;
        S_CMP:     state_d = S_WAIT;
        S_WAIT:    state_d = alu_EQ ? S_CMP : alu_G ? S_ACCEL : alu_L ? S_DECEL : S_CMP;
        S_ACCEL,
        S_DECEL:   state_d = adj_done ? S_CMP : state_q;
`ifndef CRUISE_RESUME_EN
        S_SUSPEND: state_d = S_ARMED;
`endif
        default:   state_d = state_q;
      endcase
    end
    // the hold counter only survives while staying in the same adjust state
    cnt_d = (state_d == state_q && (state_q == S_ACCEL || state_q == S_DECEL)) ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      tgt_q         <= '0;
      cnt_q         <= '0;
      d_speed_q     <= '0;
      alu_c_speed_q <= '0;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      up_q     <= state_d == S_ACCEL;
      down_q   <= state_d == S_DECEL;
      active_q <= state_d inside {S_CMP, S_WAIT, S_ACCEL, S_DECEL};
      if (state_d == S_CMP) begin
        d_speed_q     <= tgt_d;
        alu_c_speed_q <= c_speed;
      end
    end
  end

  assign mode          = 2'b00;
  assign d_speed       = d_speed_q;
  assign alu_c_speed   = alu_c_speed_q;
  assign throttle_up   = up_q;
  assign throttle_down = down_q;
  assign cruise_active = active_q;
  assign target_speed  = tgt_q;
endmodule
